// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debounce blocks.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous input bit.
module sync_ff #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) stages <= {SYNC_STAGES{RESET_LEVEL}};
    else     stages <= {stages[SYNC_STAGES-2:0], d};
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronizer plus counter-based debounce FSM for one board input.
// Edge pulses (rise/fall) are only generated when DEBOUNCE_EDGE_EN is defined.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CW          = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam state_t         RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic          din_s;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
      cnt   <= '0;
      level <= RESET_LEVEL;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end

  // Any opposite sample while qualifying drops back to the stable state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    case (state)
      STABLE_LO: begin
        if (din_s) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!din_s) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!din_s) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (din_s) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = RESET_STATE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_EDGE_EN
  // level only moves on a completed qualification, so its change is the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= level_nxt & ~level;
      fall <= ~level_nxt & level;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
